// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers line/frame geometry, pixel coordinates and lock.
// Define VGA_DEC_ERRCNT_EN to build the saturating lock-loss counter.
module vga_sync_decoder #(
    parameter int CW          = 10,
    parameter int LOCK_FRAMES = 2,
    parameter int MAX_LINE    = 1000
) (
    input  logic          CLK_100MHz,
    input  logic          reset,
    input  logic          p_tick,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          video_on,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          pix_valid,
    output logic          frame_start,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] h_active,
    output logic          locked,
    output logic          sync_err,
    output logic [15:0]   err_count
);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    localparam logic [CW-1:0] CMAX   = {CW{1'b1}};
    localparam logic [CW-1:0] TMO_AT = CW'(MAX_LINE - 1);
    localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FRAMES);

    state_t        state, state_n;
    logic          hs_d, vs_d, vo_d;
    logic [CW-1:0] hcnt, vcnt, vo_len;
    logic          hs_seen;
    logic [CW-1:0] h_ref, h_ref_n;
    logic [CW-1:0] v_ref, v_ref_n;
    logic [CW-1:0] match, match_n;
    logic          h_ref_ok, h_ref_ok_n;
    logic          v_ref_ok, v_ref_ok_n;
    logic          line_bad, line_bad_n;
    logic          err_set;

    logic          hs_rise, vs_rise, vo_rise, vo_fall;
    logic [CW-1:0] line_len, frame_len, match_inc;
    logic          line_done, tmo, h_miss;

    assign hs_rise   = hsync & ~hs_d;
    assign vs_rise   = vsync & ~vs_d;
    assign vo_rise   = video_on & ~vo_d;
    assign vo_fall   = ~video_on & vo_d;

    // Length of the line closed by this hsync edge, and frame length
    // including a line that starts on the same sample as vsync.
    assign line_len  = (hcnt == CMAX) ? hcnt : hcnt + 1'b1;
    assign frame_len = !hs_rise ? vcnt :
                       (vcnt == CMAX) ? vcnt : vcnt + 1'b1;
    assign line_done = hs_rise & hs_seen;
    assign tmo       = ~hs_rise & (hcnt >= TMO_AT);
    assign h_miss    = line_bad |
                       (line_done & h_ref_ok & (line_len != h_ref));
    assign match_inc = match + 1'b1;

    // Lock state and reference registers
    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            state    <= SEARCH;
            h_ref    <= '0;
            v_ref    <= '0;
            match    <= '0;
            h_ref_ok <= 1'b0;
            v_ref_ok <= 1'b0;
            line_bad <= 1'b0;
        end else begin
            state    <= state_n;
            h_ref    <= h_ref_n;
            v_ref    <= v_ref_n;
            match    <= match_n;
            h_ref_ok <= h_ref_ok_n;
            v_ref_ok <= v_ref_ok_n;
            line_bad <= line_bad_n;
        end
    end

    // Next-state: search for vsync, learn references, count matching frames
    always_comb begin
        state_n    = state;
        h_ref_n    = h_ref;
        v_ref_n    = v_ref;
        match_n    = match;
        h_ref_ok_n = h_ref_ok;
        v_ref_ok_n = v_ref_ok;
        line_bad_n = line_bad;
        err_set    = 1'b0;
        if (p_tick) begin
            unique case (state)
                SEARCH: begin
                    if (vs_rise) begin
                        state_n    = TRACK;
                        h_ref_ok_n = 1'b0;
                        v_ref_ok_n = 1'b0;
                        match_n    = '0;
                        line_bad_n = 1'b0;
                    end
                end
                TRACK: begin
                    if (tmo) begin
                        state_n = SEARCH;
                    end else begin
                        if (line_done) begin
                            if (!h_ref_ok) begin
                                h_ref_n    = line_len;
                                h_ref_ok_n = 1'b1;
                            end else if (line_len != h_ref) begin
                                h_ref_n    = line_len;
                                match_n    = '0;
                                line_bad_n = 1'b1;
                            end
                        end
                        if (vs_rise) begin
                            line_bad_n = 1'b0;
                            if (!v_ref_ok) begin
                                v_ref_n    = frame_len;
                                v_ref_ok_n = 1'b1;
                            end else if (frame_len == v_ref && !h_miss) begin
                                if (match_inc == LOCK_N) begin
                                    state_n = LOCKED;
                                    match_n = '0;
                                end else begin
                                    match_n = match_inc;
                                end
                            end else begin
                                v_ref_n = frame_len;
                                match_n = '0;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (tmo ||
                        (line_done && line_len != h_ref) ||
                        (vs_rise && frame_len != v_ref)) begin
                        err_set = 1'b1;
                        state_n = SEARCH;
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    // Per-sample counters, measured geometry and pixel coordinates
    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            hs_d     <= 1'b0;
            vs_d     <= 1'b0;
            vo_d     <= 1'b0;
            hcnt     <= '0;
            vcnt     <= '0;
            vo_len   <= '0;
            hs_seen  <= 1'b0;
            h_total  <= '0;
            v_total  <= '0;
            h_active <= '0;
            pix_x    <= '0;
            pix_y    <= '0;
        end else if (p_tick) begin
            hs_d <= hsync;
            vs_d <= vsync;
            vo_d <= video_on;
            if (hs_rise) begin
                h_total  <= line_len;
                hcnt     <= '0;
                h_active <= vo_len;
                vo_len   <= '0;
                hs_seen  <= 1'b1;
            end else begin
                if (hcnt != CMAX)
                    hcnt <= hcnt + 1'b1;
                if (video_on && vo_len != CMAX)
                    vo_len <= vo_len + 1'b1;
            end
            if (vs_rise) begin
                v_total <= frame_len;
                vcnt    <= '0;
            end else begin
                vcnt <= frame_len;
            end
            if (vo_rise)
                pix_x <= '0;
            else if (video_on)
                pix_x <= pix_x + 1'b1;
            if (vs_rise)
                pix_y <= '0;
            else if (vo_fall)
                pix_y <= pix_y + 1'b1;
        end
    end

    // Status flags and one-clock pulses
    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            locked      <= 1'b0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            if (p_tick) begin
                locked      <= (state_n == LOCKED);
                pix_valid   <= (state_n == LOCKED) & video_on;
                frame_start <= vs_rise & (state_n == LOCKED);
                sync_err    <= err_set;
            end
        end
    end

`ifdef VGA_DEC_ERRCNT_EN
    // Saturating count of lock losses
    always_ff @(posedge CLK_100MHz) begin
        if (reset)
            err_count <= '0;
        else if (err_set && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder on a scaled 20x12 timing
// (16x8 active, hsync samples 17-18, vsync lines 9-10).
module tb_vga_sync_decoder;

    logic       clk = 1'b0;
    logic       reset, p_tick, hsync, vsync, video_on;
    logic [9:0] pix_x, pix_y, h_total, v_total, h_active;
    logic       pix_valid, frame_start, locked, sync_err;
    logic [15:0] err_count;

    vga_sync_decoder dut (
        .CLK_100MHz (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_valid  (pix_valid),
        .frame_start(frame_start),
        .h_total    (h_total),
        .v_total    (v_total),
        .h_active   (h_active),
        .locked     (locked),
        .sync_err   (sync_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;
    int err_pulses = 0;

    // Behavioural model: whole-sample view using plain integers
    bit m_hs, m_vs, m_vo;
    int m_since, m_vorun, m_lines, m_mode, m_href, m_vref, m_good;
    bit m_have, m_dirty;
    int e_px, e_py, e_ht, e_vt, e_ha, e_ec;
    bit e_pv, e_fs, e_lk, e_se;

    function automatic int sat(int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    task automatic m_reset();
        m_hs = 0; m_vs = 0; m_vo = 0;
        m_since = 0; m_vorun = 0; m_lines = 0;
        m_mode = 0; m_href = -1; m_vref = -1; m_good = 0;
        m_have = 0; m_dirty = 0;
        e_px = 0; e_py = 0; e_ht = 0; e_vt = 0; e_ha = 0; e_ec = 0;
        e_pv = 0; e_fs = 0; e_lk = 0; e_se = 0;
    endtask

    task automatic m_idle();
        e_fs = 0;
        e_se = 0;
    endtask

    task automatic m_sample(bit hs, bit vs, bit vo);
        bit hr, vr, vor, vof, tmo, err, done;
        int len, nl, nxt;
        hr   = hs && !m_hs;
        vr   = vs && !m_vs;
        vor  = vo && !m_vo;
        vof  = !vo && m_vo;
        len  = sat(m_since + 1);
        nl   = hr ? sat(m_lines + 1) : m_lines;
        done = hr && m_have;
        tmo  = !hr && (m_since + 1 >= 1000);
        nxt  = m_mode;
        err  = 0;
        if (m_mode == 0) begin
            if (vr) begin
                nxt = 1; m_href = -1; m_vref = -1;
                m_good = 0; m_dirty = 0;
            end
        end else if (m_mode == 1) begin
            if (tmo) nxt = 0;
            else begin
                if (done) begin
                    if (m_href < 0) m_href = len;
                    else if (len != m_href) begin
                        m_href = len; m_good = 0; m_dirty = 1;
                    end
                end
                if (vr) begin
                    if (m_vref < 0) m_vref = nl;
                    else if (nl == m_vref && !m_dirty) begin
                        m_good++;
                        if (m_good == 2) nxt = 2;
                    end else begin
                        m_vref = nl; m_good = 0;
                    end
                    m_dirty = 0;
                end
            end
        end else begin
            if (tmo || (done && len != m_href) || (vr && nl != m_vref)) begin
                err = 1; nxt = 0;
            end
        end
        if (hr) begin
            e_ht = len; e_ha = m_vorun; m_vorun = 0;
        end else if (vo) m_vorun = sat(m_vorun + 1);
        m_since = hr ? 0 : sat(m_since + 1);
        if (hr) m_have = 1;
        if (vr) begin e_vt = nl; m_lines = 0; end
        else m_lines = nl;
        if (vor) e_px = 0;
        else if (vo) e_px = (e_px + 1) & 1023;
        if (vr) e_py = 0;
        else if (vof) e_py = (e_py + 1) & 1023;
        m_mode = nxt;
        e_lk = (nxt == 2);
        e_pv = (nxt == 2) && vo;
        e_fs = vr && (nxt == 2);
        e_se = err;
`ifdef VGA_DEC_ERRCNT_EN
        if (err && e_ec < 65535) e_ec++;
`endif
        m_hs = hs; m_vs = vs; m_vo = vo;
    endtask

    // Every clock: DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if ({pix_x, pix_y, pix_valid, frame_start, h_total, v_total,
                 h_active, locked, sync_err, err_count} !==
                {10'(e_px), 10'(e_py), e_pv, e_fs, 10'(e_ht), 10'(e_vt),
                 10'(e_ha), e_lk, e_se, 16'(e_ec)}) begin
                n_err++;
                $display("FAIL model t=%0t px %0d/%0d py %0d/%0d pv %b/%b fs %b/%b ht %0d/%0d vt %0d/%0d ha %0d/%0d lk %b/%b se %b/%b ec %0d/%0d",
                         $time, pix_x, e_px, pix_y, e_py, pix_valid, e_pv,
                         frame_start, e_fs, h_total, e_ht, v_total, e_vt,
                         h_active, e_ha, locked, e_lk, sync_err, e_se,
                         err_count, e_ec);
            end
        end
    end

    always @(negedge clk) begin
        if (sync_err === 1'b1) err_pulses++;
    end

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(string nm);
        chk({nm, ".pix_x"}, pix_x, 0);
        chk({nm, ".pix_y"}, pix_y, 0);
        chk({nm, ".pix_valid"}, pix_valid, 0);
        chk({nm, ".frame_start"}, frame_start, 0);
        chk({nm, ".h_total"}, h_total, 0);
        chk({nm, ".v_total"}, v_total, 0);
        chk({nm, ".h_active"}, h_active, 0);
        chk({nm, ".locked"}, locked, 0);
        chk({nm, ".sync_err"}, sync_err, 0);
        chk({nm, ".err_count"}, err_count, 0);
    endtask

    // Stimulus position and timing source
    int fr = 0, vp = 0, hp = 0;
    int stretch_fr = -1;
    bit shift = 0;

    task automatic step(bit r, bit p, bit h, bit v, bit o);
        reset = r; p_tick = p; hsync = h; vsync = v; video_on = o;
        @(posedge clk);
        if (r) m_reset();
        else if (p) m_sample(h, v, o);
        else m_idle();
        #1;
    endtask

    task automatic cur(output bit h, output bit v, output bit o);
        o = (hp < 16) && (vp < 8);
        h = (hp >= 17) && (hp <= 18);
        if (shift)
            v = (vp == 9 && hp >= 17) || vp == 10 || (vp == 11 && hp < 17);
        else
            v = (vp == 9) || (vp == 10);
    endtask

    task automatic send();
        bit h, v, o;
        int ll;
        cur(h, v, o);
        for (int i = 0; i < 3; i++) step(0, 0, h, v, o);
        step(0, 1, h, v, o);
        ll = (fr == stretch_fr && vp == 3) ? 21 : 20;
        hp++;
        if (hp == ll) begin
            hp = 0; vp++;
            if (vp == 12) begin vp = 0; fr++; end
        end
    endtask

    task automatic idle1();
        bit h, v, o;
        cur(h, v, o);
        step(0, 0, h, v, o);
    endtask

    task automatic go_to(int f, int l, int x);
        int guard = 0;
        while (!(fr == f && vp == l && hp == x)) begin
            send();
            guard++;
            if (guard > 8000) begin
                n_err++;
                $display("FAIL go_to: position %0d/%0d/%0d not reached", f, l, x);
                break;
            end
        end
    endtask

    int ep0;
    int ec_exp;

    initial begin
        m_reset();
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk_en = 1;
        chk_zero("reset");

        go_to(3, 9, 0);
        chk("lock_before_edge4", locked, 0);
        send();
        chk("lock_at_edge4", locked, 1);

        go_to(4, 0, 0);
        chk("h_total", h_total, 20);
        chk("v_total", v_total, 12);
        chk("h_active_blank", h_active, 0);
        send();
        chk("first_px", pix_x, 0);
        chk("first_py", pix_y, 0);
        chk("first_pv", pix_valid, 1);
        go_to(4, 7, 15);
        send();
        chk("last_px", pix_x, 15);
        chk("last_py", pix_y, 7);
        chk("last_pv", pix_valid, 1);
        chk("h_active", h_active, 16);
        send();
        chk("blank_pv", pix_valid, 0);
        go_to(4, 9, 0);
        send();
        chk("frame_start", frame_start, 1);
        idle1();
        chk("frame_start_clr", frame_start, 0);

        stretch_fr = 5;
        go_to(5, 4, 17);
        chk("locked_pre_stretch", locked, 1);
        send();
        chk("stretch_err", sync_err, 1);
        chk("stretch_unlock", locked, 0);
`ifdef VGA_DEC_ERRCNT_EN
        ec_exp = 1;
`else
        ec_exp = 0;
`endif
        chk("stretch_errcnt", err_count, ec_exp);
        idle1();
        chk("stretch_err_clr", sync_err, 0);
        go_to(8, 9, 0);
        chk("relock_pre", locked, 0);
        send();
        chk("relock", locked, 1);

        go_to(9, 2, 0);
        chk("locked_pre_tmo", locked, 1);
        ep0 = err_pulses;
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
            step(0, 1, 0, 0, 0);
        end
        chk("tmo_unlock", locked, 0);
        chk("tmo_pulses", err_pulses - ep0, 1);
`ifdef VGA_DEC_ERRCNT_EN
        ec_exp = 2;
`else
        ec_exp = 0;
`endif
        chk("tmo_errcnt", err_count, ec_exp);
        fr = 10; vp = 0; hp = 0;

        go_to(14, 3, 5);
        chk("locked_pre_rst", locked, 1);
        begin
            bit h, v, o;
            cur(h, v, o);
            step(1, 1, h, v, o);
            chk_zero("rst_mid");
            step(1, 1, h, v, o);
            chk_zero("rst_hold");
        end

        go_to(15, 0, 0);
        shift = 1;
        go_to(16, 9, 17);
        send();
        chk("vt_same_edge", v_total, 12);
        go_to(19, 0, 0);
        chk("vt_shift_locked", locked, 1);
        chk("vt_shift", v_total, 12);
        for (int i = 0; i < 10; i++) send();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
